// File: rtl/puf_digit_formatter_pkg.sv
// -----------------------------------------------------------------------------
// puf_digit_formatter_pkg
// Shared types and constants for the PUF digit formatter slice.
//   state_t     : FSM encoding (IDLE, SHIFT, DONE)
//   constants   : digit counts, input width, shift count, decimal maximum
//   bcd_adjust  : double-dabble per-digit correction (+3 when digit >= 5)
// -----------------------------------------------------------------------------
package puf_digit_formatter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS  = 4;
    localparam int BCD_DIGITS  = 5;
    localparam int IN_WIDTH    = 16;
    localparam int SHIFT_COUNT = 16;
    localparam int DIGIT_WIDTH = 4;
    localparam int BCD_WIDTH   = DIGIT_WIDTH * BCD_DIGITS;
    localparam int DISP_WIDTH  = DIGIT_WIDTH * NUM_DIGITS;

    localparam logic [IN_WIDTH-1:0] DEC_MAX = 16'd9999;

    // Displayed pattern when a decimal result is saturated (all nines).
    localparam logic [DISP_WIDTH-1:0] SAT_DIGITS = 16'h9999;

    // A digit >= 5 would become >= 10 after the next doubling; adding 3
    // first makes the carry land in the next digit. Stays within 4 bits
    // because only values 0..9 are ever presented.
    function automatic logic [DIGIT_WIDTH-1:0] bcd_adjust(input logic [DIGIT_WIDTH-1:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/puf_digit_formatter_if.sv
// -----------------------------------------------------------------------------
// puf_digit_formatter_if
// Bundles the input handshake and the digit output bus of the formatter.
//   master : drives in_valid/in_data/dec_mode, observes everything else
//   slave  : the formatter itself
//
// Handshake: a value transfers on a rising edge where in_valid && in_ready.
// in_ready is high only while the formatter is idle; in_valid offered while
// in_ready is low is ignored (no queue), and in_data/dec_mode only need to
// be valid on the transfer edge. out_valid is a one-cycle pulse marking the
// cycle in which the digit registers and overflow hold a fresh result.
// -----------------------------------------------------------------------------
interface puf_digit_formatter_if;
    import puf_digit_formatter_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [IN_WIDTH-1:0]    in_data;
    logic                   dec_mode;
    logic [DIGIT_WIDTH-1:0] ones;
    logic [DIGIT_WIDTH-1:0] tens;
    logic [DIGIT_WIDTH-1:0] hundreds;
    logic [DIGIT_WIDTH-1:0] thousands;
    logic                   out_valid;
    logic                   overflow;
    logic                   busy;

    modport master (
        output in_valid, in_data, dec_mode,
        input  in_ready, ones, tens, hundreds, thousands, out_valid, overflow, busy
    );

    modport slave (
        input  in_valid, in_data, dec_mode,
        output in_ready, ones, tens, hundreds, thousands, out_valid, overflow, busy
    );

endinterface

// File: rtl/bcd_dabble_step.sv
// -----------------------------------------------------------------------------
// bcd_dabble_step
// Combinational add-3 correction applied to every digit of the BCD scratch
// before the double-dabble shift. No carries cross digit boundaries.
//   scratch_in  : 20-bit BCD scratch (5 digits)
//   scratch_out : same scratch with each digit >= 5 incremented by 3
// -----------------------------------------------------------------------------
module bcd_dabble_step
    import puf_digit_formatter_pkg::*;
(
    input  logic [BCD_WIDTH-1:0] scratch_in,
    output logic [BCD_WIDTH-1:0] scratch_out
);

    always_comb begin
        scratch_out = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            scratch_out[i*DIGIT_WIDTH +: DIGIT_WIDTH] =
                bcd_adjust(scratch_in[i*DIGIT_WIDTH +: DIGIT_WIDTH]);
        end
    end

endmodule

// File: rtl/puf_digit_formatter.sv
// -----------------------------------------------------------------------------
// puf_digit_formatter
// Turns a 16-bit value into four display digits. Hex mode splits nibbles;
// decimal mode runs a 16-step double-dabble (one shift per clock) with
// optional saturation to 9999 when the value exceeds four decimal digits.
// Digit outputs only change on the DONE->IDLE edge so a multiplexed display
// never sees partial results.
//   clk_100MHz : system clock
//   reset      : asynchronous, active-high; aborts any conversion
//   bus        : handshake + digit outputs (slave side)
//   dbg_state  : current FSM state
// Parameter SAT_ON_OVF: 1 shows 9999 on decimal overflow, 0 shows the low
// four BCD digits. overflow is flagged either way.
// -----------------------------------------------------------------------------
module puf_digit_formatter
    import puf_digit_formatter_pkg::*;
#(
    parameter bit SAT_ON_OVF = 1'b1
)(
    input  logic                    clk_100MHz,
    input  logic                    reset,
    puf_digit_formatter_if.slave    bus,
    output state_t                  dbg_state
);

    state_t                 state_q,     state_d;
    logic [IN_WIDTH-1:0]    shreg_q,     shreg_d;
    logic [BCD_WIDTH-1:0]   scratch_q,   scratch_d;
    logic [3:0]             cnt_q,       cnt_d;
    logic                   dec_q,       dec_d;
    logic [DISP_WIDTH-1:0]  digits_q,    digits_d;
    logic                   out_valid_q, out_valid_d;
    logic                   overflow_q,  overflow_d;

    logic [BCD_WIDTH-1:0]   scratch_adj;
    logic                   accept;

    bcd_dabble_step u_step (
        .scratch_in  (scratch_q),
        .scratch_out (scratch_adj)
    );

    assign accept = (state_q == IDLE) && bus.in_valid;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        dec_d       = dec_q;
        digits_d    = digits_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = bus.in_data;
                    scratch_d = '0;
                    dec_d     = bus.dec_mode;
                    cnt_d     = '0;
                    state_d   = bus.dec_mode ? SHIFT : DONE;
                end
            end

            SHIFT: begin
                // Correction and shift in the same cycle; the MSB of the
                // corrected scratch is always zero for 16-bit inputs.
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(SHIFT_COUNT - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                out_valid_d = 1'b1;
                state_d     = IDLE;
                if (!dec_q) begin
                    // No shifts happened, so shreg still holds the input.
                    digits_d   = shreg_q;
                    overflow_d = 1'b0;
                end else if (scratch_q[BCD_WIDTH-1 -: DIGIT_WIDTH] != '0) begin
                    // A nonzero fifth digit means the value exceeded DEC_MAX.
                    overflow_d = 1'b1;
                    digits_d   = SAT_ON_OVF ? SAT_DIGITS : scratch_q[DISP_WIDTH-1:0];
                end else begin
                    overflow_d = 1'b0;
                    digits_d   = scratch_q[DISP_WIDTH-1:0];
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            dec_q       <= 1'b0;
            digits_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            dec_q       <= dec_d;
            digits_q    <= digits_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.ones      = digits_q[3:0];
    assign bus.tens      = digits_q[7:4];
    assign bus.hundreds  = digits_q[11:8];
    assign bus.thousands = digits_q[15:12];
    assign bus.out_valid = out_valid_q;
    assign bus.overflow  = overflow_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_puf_digit_formatter.sv
// -----------------------------------------------------------------------------
// tb_puf_digit_formatter
// Directed bench for puf_digit_formatter. Two instances run in lockstep on
// the same stimulus: one saturating (SAT_ON_OVF=1), one not (SAT_ON_OVF=0).
// -----------------------------------------------------------------------------
module tb_puf_digit_formatter;
    import puf_digit_formatter_pkg::*;

    logic   clk_100MHz;
    logic   reset;
    state_t dbg_sat;
    state_t dbg_raw;

    int n_vec;
    int n_bad;

    puf_digit_formatter_if bus_sat ();
    puf_digit_formatter_if bus_raw ();

    puf_digit_formatter #(.SAT_ON_OVF(1'b1)) dut_sat (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus_sat),
        .dbg_state  (dbg_sat)
    );

    puf_digit_formatter #(.SAT_ON_OVF(1'b0)) dut_raw (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .bus        (bus_raw),
        .dbg_state  (dbg_raw)
    );

    // clock / reset
    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    // helpers
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic m);
        bus_sat.in_valid = v;
        bus_sat.in_data  = d;
        bus_sat.dec_mode = m;
        bus_raw.in_valid = v;
        bus_raw.in_data  = d;
        bus_raw.dec_mode = m;
    endtask

    function automatic logic [15:0] digs_sat();
        return {bus_sat.thousands, bus_sat.hundreds, bus_sat.tens, bus_sat.ones};
    endfunction

    function automatic logic [15:0] digs_raw();
        return {bus_raw.thousands, bus_raw.hundreds, bus_raw.tens, bus_raw.ones};
    endfunction

    // One full conversion with latency, busy-length and stability checks.
    task automatic run_conv(input string name, input logic [15:0] val, input logic dm,
                            input logic [15:0] exp_sat, input logic [15:0] exp_raw,
                            input logic exp_ovf, input int exp_lat);
        int          lat;
        int          busy_cycles;
        bit          stable;
        logic [15:0] prev;
        chk({name, "_pre_ready"}, bus_sat.in_ready, 1'b1);
        prev = digs_sat();
        drive(1'b1, val, dm);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        chk({name, "_busy_ready_after_accept"}, {bus_sat.busy, bus_sat.in_ready}, 2'b10);
        lat         = 0;
        busy_cycles = 1;
        stable      = 1'b1;
        while (lat < 40) begin
            step();
            lat++;
            if (bus_sat.out_valid) break;
            if (digs_sat() !== prev) stable = 1'b0;
            if (bus_sat.busy) busy_cycles++;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, busy_cycles, exp_lat);
        chk({name, "_digits_stable"}, stable, 1'b1);
        chk({name, "_digits_sat"}, digs_sat(), exp_sat);
        chk({name, "_digits_raw"}, digs_raw(), exp_raw);
        chk({name, "_ovf_sat"}, bus_sat.overflow, exp_ovf);
        chk({name, "_ovf_raw"}, bus_raw.overflow, exp_ovf);
        chk({name, "_ready_with_valid"}, bus_sat.in_ready, 1'b1);
        step();
        chk({name, "_valid_pulse_end"}, bus_sat.out_valid, 1'b0);
    endtask

    // main sequence
    initial begin
        int k;
        bit seen;
        n_vec = 0;
        n_bad = 0;
        drive(1'b0, 16'h0000, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_digits", digs_sat(), 16'h0000);
        chk("rst_flags", {bus_sat.out_valid, bus_sat.overflow, bus_sat.busy, bus_sat.in_ready}, 4'b0001);
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b0;
        step();

        run_conv("hex_beef", 16'hBEEF, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0, 1);
        run_conv("dec_1234", 16'd1234, 1'b1, 16'h1234, 16'h1234, 1'b0, 17);
        run_conv("dec_0",    16'd0,    1'b1, 16'h0000, 16'h0000, 1'b0, 17);
        run_conv("dec_9999", 16'd9999, 1'b1, 16'h9999, 16'h9999, 1'b0, 17);
        run_conv("dec_10000", 16'd10000, 1'b1, 16'h9999, 16'h0000, 1'b1, 17);
        run_conv("dec_65535", 16'd65535, 1'b1, 16'h9999, 16'h5535, 1'b1, 17);

        // in_valid held high: 42 decimal, junk while busy, then 0x00A5 hex.
        chk("held_pre_ready", bus_sat.in_ready, 1'b1);
        drive(1'b1, 16'd42, 1'b1);
        step();
        k    = 0;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            drive(1'b1, 16'hF00D ^ 16'(k * 16'h0101), 1'(k));
            step();
            k++;
            if (bus_sat.out_valid) seen = 1'b1;
        end
        chk("held_first_latency", k, 17);
        chk("held_first_digits", digs_sat(), 16'h0042);
        chk("held_first_ovf", bus_sat.overflow, 1'b0);
        drive(1'b1, 16'h00A5, 1'b0);
        step();
        chk("held_second_accepted", {bus_sat.in_ready, bus_sat.out_valid}, 2'b00);
        drive(1'b0, 16'h0000, 1'b0);
        step();
        chk("held_second_valid", bus_sat.out_valid, 1'b1);
        chk("held_second_digits", digs_sat(), 16'h00A5);
        chk("held_second_ovf", {bus_sat.overflow, bus_raw.overflow}, 2'b00);
        step();

        // Reset in the middle of a decimal conversion.
        run_conv("pre_rst_10000", 16'd10000, 1'b1, 16'h9999, 16'h0000, 1'b1, 17);
        drive(1'b1, 16'd4321, 1'b1);
        step();
        drive(1'b0, 16'h0000, 1'b0);
        repeat (8) step();
        chk("midshift_busy", bus_sat.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("abort_digits_sat", digs_sat(), 16'h0000);
        chk("abort_digits_raw", digs_raw(), 16'h0000);
        chk("abort_flags", {bus_sat.out_valid, bus_sat.overflow, bus_sat.busy, bus_sat.in_ready}, 4'b0001);
        chk("abort_ovf_raw", bus_raw.overflow, 1'b0);
        repeat (2) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        reset = 1'b0;
        step();
        run_conv("dec_7_after_rst", 16'd7, 1'b1, 16'h0007, 16'h0007, 1'b0, 17);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
